// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute stage: opcodes, operand-B
// source selects, FSM state encoding and default geometry.
package vec_pkg;

    localparam int EW_DEF    = 8;
    localparam int LANES_DEF = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_MAX = 4'd8;
    localparam logic [3:0] OP_MIN = 4'd9;

    localparam logic [1:0] SRC_VEC2 = 2'd0;
    localparam logic [1:0] SRC_SCA  = 2'd1;
    localparam logic [1:0] SRC_IMM  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vec_lane_alu.sv
// One-lane combinational ALU used by the element-serial execute stage.
// Build option: define EXE_VEC_SAT_EN to make ADD/SUB saturate (unsigned)
// instead of wrapping.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int EW = EW_DEF
) (
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    input  logic [2:0]    shamt,
    input  logic [3:0]    opcode,
    output logic [EW-1:0] y
);

`ifdef EXE_VEC_SAT_EN
    logic [EW:0] sum;
    assign sum = {1'b0, a} + {1'b0, b};
`endif

    // Lane operation select; unused opcodes yield zero.
    always_comb begin
        y = '0;
        case (opcode)
`ifdef EXE_VEC_SAT_EN
            OP_ADD: y = sum[EW] ? '1 : sum[EW-1:0];
            OP_SUB: y = (a < b) ? '0 : (a - b);
`else
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
`endif
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: y = a << shamt;
            OP_SHR: y = a >> shamt;
            OP_MOV: y = b;
            OP_MAX: y = (a > b) ? a : b;
            OP_MIN: y = (a < b) ? a : b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/exe_vec_seq.sv
// Execute stage: accepts one decoded vector op, processes one lane per
// clock, then presents the assembled result to EXE/MEM until taken.
// Build option: EXE_VEC_SAT_EN (saturating ADD/SUB in vec_lane_alu).
module exe_vec_seq
    import vec_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int EW    = EW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    input  logic [3:0]          opcode_in,
    input  logic [1:0]          sel_vec_in,
    input  logic [LANES*EW-1:0] VEC1_in,
    input  logic [LANES*EW-1:0] VEC2_in,
    input  logic [EW-1:0]       sca1_in,
    input  logic [EW-1:0]       inmediato_in,
    input  logic [EW-1:0]       shift_in,
    input  logic [2:0]          dir_dest_in,
    input  logic [7:0]          ctrl_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*EW-1:0] result_out,
    output logic [2:0]          dir_dest_out,
    output logic [7:0]          ctrl_out
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

    state_t              state_q, state_d;
    logic [LW-1:0]       lane_q;
    logic [3:0]          opcode_q;
    logic [1:0]          sel_q;
    logic [LANES*EW-1:0] vec1_q;
    logic [LANES*EW-1:0] vec2_q;
    logic [EW-1:0]       sca_q;
    logic [EW-1:0]       imm_q;
    logic [2:0]          shamt_q;
    logic [LANES*EW-1:0] result_q;
    logic [2:0]          dest_q;
    logic [7:0]          ctrl_q;

    logic                accept;
    logic [EW-1:0]       a_lane;
    logic [EW-1:0]       b_lane;
    logic [EW-1:0]       y_lane;

    // Only the low three shift bits select a shift amount.
    logic unused_shift_hi;
    assign unused_shift_hi = ^shift_in[EW-1:3];

    // Flush blocks acceptance; DONE accepts only when the result drains.
    assign in_ready  = !flush && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE) && !flush;

    assign result_out   = result_q;
    assign dir_dest_out = dest_q;
    assign ctrl_out     = ctrl_q;

    // Operand-B source for the current lane; reserved select gives zero.
    always_comb begin
        a_lane = vec1_q[lane_q*EW +: EW];
        b_lane = '0;
        case (sel_q)
            SRC_VEC2: b_lane = vec2_q[lane_q*EW +: EW];
            SRC_SCA:  b_lane = sca_q;
            SRC_IMM:  b_lane = imm_q;
            default:  b_lane = '0;
        endcase
    end

    vec_lane_alu #(.EW(EW)) u_alu (
        .a      (a_lane),
        .b      (b_lane),
        .shamt  (shamt_q),
        .opcode (opcode_q),
        .y      (y_lane)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = ST_RUN;
                ST_RUN:  if (lane_q == LANE_LAST) state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = accept ? ST_RUN : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Operand latch, lane counter and per-lane result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q   <= '0;
            opcode_q <= '0;
            sel_q    <= '0;
            vec1_q   <= '0;
            vec2_q   <= '0;
            sca_q    <= '0;
            imm_q    <= '0;
            shamt_q  <= '0;
            result_q <= '0;
            dest_q   <= '0;
            ctrl_q   <= '0;
        end else if (flush) begin
            lane_q <= '0;
        end else if (accept) begin
            lane_q   <= '0;
            opcode_q <= opcode_in;
            sel_q    <= sel_vec_in;
            vec1_q   <= VEC1_in;
            vec2_q   <= VEC2_in;
            sca_q    <= sca1_in;
            imm_q    <= inmediato_in;
            shamt_q  <= shift_in[2:0];
            result_q <= '0;
            dest_q   <= dir_dest_in;
            ctrl_q   <= ctrl_in;
        end else if (state_q == ST_RUN) begin
            result_q[lane_q*EW +: EW] <= y_lane;
            lane_q <= lane_q + LW'(1);
        end
    end

endmodule

// File: tb/tb_exe_vec_seq.sv
// Self-checking bench for exe_vec_seq: directed cases plus randomized
// operations compared against a lane-by-lane arithmetic reference model.
module tb_exe_vec_seq;

    localparam int LANES = 4;
    localparam int EW    = 8;
    localparam int VW    = LANES * EW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic [3:0]    opcode_in = '0;
    logic [1:0]    sel_vec_in = '0;
    logic [VW-1:0] VEC1_in = '0;
    logic [VW-1:0] VEC2_in = '0;
    logic [EW-1:0] sca1_in = '0;
    logic [EW-1:0] inmediato_in = '0;
    logic [EW-1:0] shift_in = '0;
    logic [2:0]    dir_dest_in = '0;
    logic [7:0]    ctrl_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] result_out;
    logic [2:0]    dir_dest_out;
    logic [7:0]    ctrl_out;

    int n_compared   = 0;
    int n_mismatched = 0;

    exe_vec_seq #(.LANES(LANES), .EW(EW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .opcode_in    (opcode_in),
        .sel_vec_in   (sel_vec_in),
        .VEC1_in      (VEC1_in),
        .VEC2_in      (VEC2_in),
        .sca1_in      (sca1_in),
        .inmediato_in (inmediato_in),
        .shift_in     (shift_in),
        .dir_dest_in  (dir_dest_in),
        .ctrl_in      (ctrl_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_out   (result_out),
        .dir_dest_out (dir_dest_out),
        .ctrl_out     (ctrl_out)
    );

    always #5 clk = ~clk;

    // Reference: each lane computed with plain integer arithmetic.
    function automatic logic [VW-1:0] refModel(input int op, input int sel,
            input logic [VW-1:0] v1, input logic [VW-1:0] v2,
            input int sca, input int imm, input int sh);
        logic [VW-1:0] res;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            int a, b, r;
            a = int'(v1[i*EW +: EW]);
            case (sel)
                0: b = int'(v2[i*EW +: EW]);
                1: b = sca;
                2: b = imm;
                default: b = 0;
            endcase
            case (op)
                0: begin
                    r = a + b;
`ifdef EXE_VEC_SAT_EN
                    if (r > 255) r = 255;
`endif
                end
                1: begin
                    r = a - b;
`ifdef EXE_VEC_SAT_EN
                    if (r < 0) r = 0;
`endif
                end
                2: r = a & b;
                3: r = a | b;
                4: r = a ^ b;
                5: r = a * (2 ** (sh % 8));
                6: r = a / (2 ** (sh % 8));
                7: r = b;
                8: r = (a > b) ? a : b;
                9: r = (a < b) ? a : b;
                default: r = 0;
            endcase
            res[i*EW +: EW] = 8'(r);
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int op, input int sel,
            input logic [VW-1:0] v1, input logic [VW-1:0] v2,
            input int sca, input int imm, input int sh,
            input int dest, input int ctrl);
        opcode_in    = 4'(op);
        sel_vec_in   = 2'(sel);
        VEC1_in      = v1;
        VEC2_in      = v2;
        sca1_in      = 8'(sca);
        inmediato_in = 8'(imm);
        shift_in     = 8'(sh);
        dir_dest_in  = 3'(dest);
        ctrl_in      = 8'(ctrl);
        in_valid     = 1'b1;
    endtask

    // Called at a negedge; returns right after the accepting posedge.
    task automatic acceptOp(input int op, input int sel,
            input logic [VW-1:0] v1, input logic [VW-1:0] v2,
            input int sca, input int imm, input int sh,
            input int dest, input int ctrl);
        int w;
        out_ready = 1'b1;
        applyStimulus(op, sel, v1, v2, sca, imm, sh, dest, ctrl);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    // Waits for the result, checks latency and fields, then holds
    // out_ready low for 'stall' cycles checking the result stays put.
    task automatic waitDone(input string tag, input logic [VW-1:0] exp_res,
            input int exp_dest, input int exp_ctrl, input int stall);
        int lat;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = (stall == 0);
        checkOutput({tag, "_run_in_ready"}, 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(LANES + 1));
        checkOutput({tag, "_result"}, result_out, exp_res);
        checkOutput({tag, "_dest"}, 32'(dir_dest_out), 32'(exp_dest));
        checkOutput({tag, "_ctrl"}, 32'(ctrl_out), 32'(exp_ctrl));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_hold_result"}, result_out, exp_res);
            checkOutput({tag, "_hold_dest"}, 32'(dir_dest_out), 32'(exp_dest));
            checkOutput({tag, "_hold_ctrl"}, 32'(ctrl_out), 32'(exp_ctrl));
        end
        out_ready = 1'b1;
    endtask

    // Directed scenarios followed by randomized operations.
    initial begin
        logic [VW-1:0] exp_ovf;
        logic          seen;
`ifdef EXE_VEC_SAT_EN
        exp_ovf = 32'hFFFFFF03;
`else
        exp_ovf = 32'h00000003;
`endif
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_result", result_out, 32'd0);
        checkOutput("rst_dest", 32'(dir_dest_out), 32'd0);
        checkOutput("rst_ctrl", 32'(ctrl_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        acceptOp(0, 0, 32'h01020304, 32'h10203040, 0, 0, 0, 3, 8'h5A);
        waitDone("add", 32'h11223344, 3, 8'h5A, 0);
        acceptOp(0, 0, 32'hFF80FF01, 32'h01800102, 0, 0, 0, 1, 8'h11);
        waitDone("ovf", exp_ovf, 1, 8'h11, 0);
        acceptOp(7, 1, 32'hDEADBEEF, 32'h12345678, 8'h05, 8'h77, 0, 2, 8'h22);
        waitDone("mov_sca", 32'h05050505, 2, 8'h22, 0);
        acceptOp(6, 0, 32'h80402010, 32'h0, 0, 0, 4, 4, 8'h33);
        waitDone("shr", 32'h08040201, 4, 8'h33, 0);
        @(negedge clk);

        // Backpressure then a bundle accepted on the draining edge.
        acceptOp(4, 2, 32'hA5A5A5A5, 32'h0, 0, 8'hFF, 0, 6, 8'hC3);
        waitDone("bp", 32'h5A5A5A5A, 6, 8'hC3, 3);
        acceptOp(1, 0, 32'h10203040, 32'h01020304, 0, 0, 0, 7, 8'h81);
        waitDone("b2b", 32'h0F1E2D3C, 7, 8'h81, 0);
        @(negedge clk);

        // Flush at lane 2 with a competing in_valid.
        acceptOp(0, 0, 32'h11111111, 32'h22222222, 0, 0, 0, 5, 8'h44);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        applyStimulus(2, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 1);
        #1;
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("post_flush_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        checkOutput("flush_no_valid", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of RUN.
        acceptOp(0, 0, 32'h01020304, 32'h10203040, 0, 0, 0, 5, 8'hA5);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("arst_result", result_out, 32'd0);
        checkOutput("arst_dest", 32'(dir_dest_out), 32'd0);
        checkOutput("arst_ctrl", 32'(ctrl_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        acceptOp(8, 0, 32'h10F02080, 32'h20E03070, 0, 0, 0, 2, 8'h0F);
        waitDone("after_rst", 32'h20F03080, 2, 8'h0F, 0);

        // Randomized operations with random stalls and idle gaps.
        for (int k = 0; k < 40; k++) begin
            int op, sel, sca, imm, sh, dest, ctrl, stall;
            logic [VW-1:0] v1, v2;
            op    = int'($urandom_range(0, 15));
            sel   = int'($urandom_range(0, 3));
            v1    = $urandom;
            v2    = $urandom;
            sca   = int'($urandom_range(0, 255));
            imm   = int'($urandom_range(0, 255));
            sh    = int'($urandom_range(0, 255));
            dest  = int'($urandom_range(0, 7));
            ctrl  = int'($urandom_range(0, 255));
            stall = int'($urandom_range(0, 3));
            acceptOp(op, sel, v1, v2, sca, imm, sh, dest, ctrl);
            waitDone("rand", refModel(op, sel, v1, v2, sca, imm, sh),
                     dest, ctrl, stall);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
